// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and EX-resolution bus between the pipeline and the branch predictor.
interface branch_predict_unit_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic             if_valid;
    logic [PC_W-1:0]  if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic [31:0]      ex_imm;
    logic             ex_branch;
    logic [1:0]       ex_jump_type;
    logic [31:0]      ex_alu_result;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic [31:0]      pc_four;
    logic [31:0]      pc_imm;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output if_valid, if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jump_type,
               ex_alu_result, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, pc_four, pc_imm, redirect, redirect_pc,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_valid, if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jump_type,
               ex_alu_result, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, pc_four, pc_imm, redirect, redirect_pc,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// BTB + 2-bit BHT predictor with EX-stage resolution, registered redirect and
// saturating branch/mispredict statistics.
module branch_predict_unit #(
    parameter int PC_W  = 9,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [1:0] JT_JALR = 2'b01;
    localparam logic [1:0] JT_JAL  = 2'b10;

    logic             r_valid  [DEPTH];
    logic [1:0]       r_ctr    [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic             r_jmp    [DEPTH];

    logic             r_redirect_p1;
    logic [31:0]      r_redirect_pc_p1;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Fetch-side lookup against the registered tables
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;

    assign w_if_idx        = bus.if_pc[IDX_W+1:2];
    assign w_if_tag        = bus.if_pc[PC_W-1:IDX_W+2];
    assign w_if_hit        = bus.if_valid && r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign bus.pred_taken  = w_if_hit && (r_jmp[w_if_idx] || r_ctr[w_if_idx][1]);
    assign bus.pred_target = bus.pred_taken ? r_target[w_if_idx] : 32'd0;

    // EX-side resolution (p0)
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic [31:0]      w_ex_pc32;
    logic [31:0]      w_pc_four;
    logic [31:0]      w_pc_imm;
    logic [31:0]      w_act_target;
    logic             w_jalr;
    logic             w_jal;
    logic             w_br;
    logic             w_act_taken;
    logic             w_mispred_p0;
    logic             w_counted_p0;

    assign w_ex_idx     = bus.ex_pc[IDX_W+1:2];
    assign w_ex_tag     = bus.ex_pc[PC_W-1:IDX_W+2];
    assign w_ex_pc32    = 32'(bus.ex_pc);
    assign w_pc_four    = w_ex_pc32 + 32'd4;
    assign w_pc_imm     = w_ex_pc32 + bus.ex_imm;
    assign w_jalr       = bus.ex_valid && (bus.ex_jump_type == JT_JALR);
    assign w_jal        = bus.ex_valid && (bus.ex_jump_type == JT_JAL);
    // Reserved jump type 11 falls through here as "no jump"
    assign w_br         = bus.ex_valid && bus.ex_branch && !w_jalr && !w_jal;
    assign w_act_taken  = w_jalr || w_jal || (w_br && bus.ex_alu_result[0]);
    assign w_act_target = w_jalr ? {bus.ex_alu_result[31:1], 1'b0} : w_pc_imm;
    assign w_mispred_p0 = bus.ex_valid &&
                          ((w_act_taken != bus.ex_pred_taken) ||
                           (w_act_taken && (bus.ex_pred_target != w_act_target)));
    assign w_counted_p0 = bus.ex_valid && (bus.ex_branch || w_jalr || w_jal);

    assign bus.pc_four     = w_pc_four;
    assign bus.pc_imm      = w_pc_imm;
    assign bus.redirect    = r_redirect_p1;
    assign bus.redirect_pc = r_redirect_pc_p1;
    assign bus.branch_cnt  = r_branch_cnt;
    assign bus.mispred_cnt = r_mispred_cnt;

    // p0 -> p1: redirect, statistics and entry state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
            r_redirect_p1    <= 1'b0;
            r_redirect_pc_p1 <= 32'd0;
            r_branch_cnt     <= '0;
            r_mispred_cnt    <= '0;
        end else begin
            r_redirect_p1 <= w_mispred_p0;
            if (w_mispred_p0) begin
                r_redirect_pc_p1 <= w_act_taken ? w_act_target : w_pc_four;
                r_mispred_cnt    <= sat_inc(r_mispred_cnt);
            end
            if (w_counted_p0) r_branch_cnt <= sat_inc(r_branch_cnt);
            if (w_jal) begin
                r_valid[w_ex_idx] <= 1'b1;
                r_ctr[w_ex_idx]   <= 2'b11;
            end else if (w_br) begin
                r_ctr[w_ex_idx] <= ctr_step(r_ctr[w_ex_idx], bus.ex_alu_result[0]);
                if (bus.ex_alu_result[0]) r_valid[w_ex_idx] <= 1'b1;
            end
        end
    end

    // Entry payload is qualified by r_valid, so it carries no reset
    always_ff @(posedge clk) begin
        if (w_jal || (w_br && bus.ex_alu_result[0])) begin
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= w_pc_imm;
            r_jmp[w_ex_idx]    <= w_jal;
        end
    end
endmodule
